// File: rtl/sfq_xort_driver.sv
// Operand FIFO plus sequencer that drives one clocked XOR-T cell with toggle-encoded pulses
// and checks its toggle-encoded q response against a ^ b.
module sfq_xort_driver #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AB_GAP    = 2,
    parameter int unsigned CLK_GAP   = 4,
    parameter int unsigned RESP_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_a,
    input  logic in_b,
    output logic a_out,
    output logic b_out,
    output logic clk_out,
    input  logic q_in,
    output logic res_valid,
    output logic res_q,
    output logic res_err,
    output logic stray_q,
    output logic busy
);

    localparam int unsigned MaxAbClk = (AB_GAP > CLK_GAP) ? AB_GAP : CLK_GAP;
    localparam int unsigned MaxGap   = (MaxAbClk > RESP_WAIT) ? MaxAbClk : RESP_WAIT;
    localparam int unsigned CW       = $clog2(MaxGap + 1);
    localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NW       = $clog2(DEPTH + 1);

    // Gap counters count down to zero, so a gap of N extra cycles loads N-1.
    localparam logic [CW-1:0] AbLoad   = CW'((AB_GAP > 1) ? AB_GAP - 2 : 0);
    localparam logic [CW-1:0] ClkLoad  = CW'((CLK_GAP > 1) ? CLK_GAP - 2 : 0);
    localparam logic [CW-1:0] WaitLoad = CW'(RESP_WAIT - 1);
    localparam logic [NW-1:0] Full     = NW'(DEPTH);
    localparam logic [PW-1:0] LastPtr  = PW'(DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle, StSendA, StGapAb, StSendB, StGapClk, StSendClk, StWaitQ, StReport
    } state_e;

    state_e        state;
    logic [1:0]    mem [DEPTH];
    logic [1:0]    head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count, count_d;
    logic          push, pop;
    logic [CW-1:0] cnt;
    logic          a_lat, b_lat;
    logic          q_s1, q_s2, q_prev, q_edge;
    logic [1:0]    q_cnt, q_cnt_d;
    logic          res_q_d;

    assign head = mem[rd_ptr];
    assign busy = (state != StIdle) || (count != '0);

    always_comb begin
        push    = in_valid && in_ready;
        pop     = (state == StIdle) && (count != '0);
        count_d = count;
        if (push && !pop) begin
            count_d = count + NW'(1);
        end else if (!push && pop) begin
            count_d = count - NW'(1);
        end
        q_cnt_d = q_cnt;
        if ((state == StWaitQ) && q_edge && (q_cnt != 2'd2)) begin
            q_cnt_d = q_cnt + 2'd1;
        end
        res_q_d = (q_cnt_d == 2'd1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PW'(1);
            end
            count    <= count_d;
            in_ready <= (count_d != Full);
        end
    end

    // Two-flop synchronizer, previous-value register and a registered edge flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_s1   <= 1'b0;
            q_s2   <= 1'b0;
            q_prev <= 1'b0;
            q_edge <= 1'b0;
        end else begin
            q_s1   <= q_in;
            q_s2   <= q_s1;
            q_prev <= q_s2;
            q_edge <= q_s2 ^ q_prev;
        end
    end

    // Pulse toggles are issued on entry to each SEND state so they appear during that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= '0;
            a_lat     <= 1'b0;
            b_lat     <= 1'b0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            clk_out   <= 1'b0;
            res_valid <= 1'b0;
            res_q     <= 1'b0;
            res_err   <= 1'b0;
            stray_q   <= 1'b0;
            q_cnt     <= 2'd0;
        end else begin
            q_cnt     <= q_cnt_d;
            res_valid <= 1'b0;
            if (q_edge && (state != StWaitQ)) begin
                stray_q <= 1'b1;
            end
            unique case (state)
                StIdle: begin
                    if (pop) begin
                        a_lat <= head[1];
                        b_lat <= head[0];
                        a_out <= a_out ^ head[1];
                        state <= StSendA;
                    end
                end
                StSendA: begin
                    if (AB_GAP > 1) begin
                        cnt   <= AbLoad;
                        state <= StGapAb;
                    end else begin
                        b_out <= b_out ^ b_lat;
                        state <= StSendB;
                    end
                end
                StGapAb: begin
                    if (cnt == '0) begin
                        b_out <= b_out ^ b_lat;
                        state <= StSendB;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                StSendB: begin
                    if (CLK_GAP > 1) begin
                        cnt   <= ClkLoad;
                        state <= StGapClk;
                    end else begin
                        clk_out <= ~clk_out;
                        state   <= StSendClk;
                    end
                end
                StGapClk: begin
                    if (cnt == '0) begin
                        clk_out <= ~clk_out;
                        state   <= StSendClk;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                StSendClk: begin
                    q_cnt <= 2'd0;
                    cnt   <= WaitLoad;
                    state <= StWaitQ;
                end
                StWaitQ: begin
                    if (cnt == '0) begin
                        res_valid <= 1'b1;
                        res_q     <= res_q_d;
                        res_err   <= q_cnt_d[1] || (res_q_d != (a_lat ^ b_lat));
                        state     <= StReport;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                StReport: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
